axi_lite_master: RTL and testbench
==================================

# axi_lite_master

AXI-lite initiator that converts the core's single-beat load/store request interface into AXI-lite read or write transactions toward a memory-side AXI-lite slave such as the DRAM model. It sits between the LSU/IFU arbiter and the memory slave. It has exactly one transaction outstanding at a time. All AXI outputs are driven from flops.

## Interface
- ADDR_WIDTH, 32, address width of request and AXI address channels
- DATA_WIDTH, 32, data width of request, response and AXI data channels
- STRB_WIDTH, DATA_WIDTH/8, byte-strobe width
- clk_i  in  1  single clock; all logic on posedge
- rst_i  in  1  reset, synchronous, active-high
- req_valid_i / req_ready_o  in/out  1  core request handshake
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  ADDR_WIDTH  request address
- req_wdata_i / req_wstrb_i  in  DATA_WIDTH / STRB_WIDTH  write data and byte mask
- resp_valid_o / resp_ready_i  out/in  1  core response handshake
- resp_rdata_o  out  DATA_WIDTH  read data; 0 for writes
- resp_err_o  out  1  1 when bresp_i != 2'b00 on a write; always 0 on reads
- araddr_o, arvalid_o / arready_i  out, out/in  ADDR_WIDTH, 1  AXI read address channel
- rdata_i, rvalid_i / rready_o  in, in/out  DATA_WIDTH, 1  AXI read data channel
- awaddr_o, awvalid_o / awready_i  out, out/in  ADDR_WIDTH, 1  AXI write address channel
- wdata_o, wstrb_o, wvalid_o / wready_i  out  DATA_WIDTH, STRB_WIDTH, 1  AXI write data channel (wready_i is in)
- bresp_i, bvalid_i / bready_o  in, in/out  2, 1  AXI write response channel

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- IDLE: req_ready_o=1. On req fire: latch addr/wdata/wstrb/we. Go to RD_ADDR (we=0) or WR_REQ (we=1).
- RD_ADDR: arvalid_o=1 with latched address. On ar fire (arvalid_o && arready_i), go to RD_DATA.
- RD_DATA: rready_o=1. On r fire, capture rdata_i into resp_rdata_o, clear resp_err_o, go to RESP.
- WR_REQ: awvalid_o and wvalid_o both assert on entry. Each channel tracks its own done flag and drops its valid the cycle after its own handshake.
  - Leave for WR_RESP once both flags are set.
  - AW and W firing in the same cycle goes directly to WR_RESP.
  - W may fire before AW, or AW before W.
- WR_RESP: bready_o=1. On b fire, set resp_err_o = (bresp_i != 0), set resp_rdata_o = 0, go to RESP.
- RESP: resp_valid_o=1; response fields are held stable. On resp fire, go to IDLE.
- AXI rule: address, data and strobe outputs stay constant while their valid is high and ready is low. A valid is never withdrawn before its handshake.
- rready_o/bready_o are only asserted in their own state. An rvalid_i/bvalid_i arriving earlier is left pending and is taken on entry.

## Timing
- Reset values: every valid, ready and AXI output is 0; req_ready_o=0 during the reset cycle; state=IDLE. resp_rdata_o=0, resp_err_o=0, done flags cleared.
- req_ready_o becomes 1 the first cycle after rst_i deasserts.
- Cycle N: req fire. Cycle N+1: arvalid_o (or awvalid_o+wvalid_o) high.
- Read with zero-wait slave (ready/valid immediately): ar fire N+1, r fire N+2, resp_valid_o N+3. Minimum request-to-response is 3 cycles.
- Write, same minimum: aw/w fire N+1, b fire N+2, resp_valid_o N+3.
- resp_ready_i high while resp_valid_o: resp fire that cycle, req_ready_o high the next cycle. There is no back-to-back request acceptance in the response cycle.
- Core stalls on resp_ready_i=0: resp_valid_o and data are held indefinitely.
- Reset mid-transaction: all outputs return to reset values on the next edge. The outstanding AXI transaction is abandoned; the slave is reset alongside.
- There is no timeout; a slave that never responds stalls the block.

## Test plan
- Read, zero-wait slave: req addr=0x8000_0010, slave returns 0xDEADBEEF -> arvalid_o at N+1, araddr_o=0x8000_0010, resp_valid_o at N+3, resp_rdata_o=0xDEADBEEF, resp_err_o=0.
- Read, slow slave: arready_i delayed 4 cycles, rvalid_i 10 cycles after ar fire -> araddr_o is stable throughout, exactly one ar fire and one r fire, correct data.
- Write with skewed channels: wdata=0x1234_5678, wstrb=4'b0011; wready_i at N+1, awready_i at N+5 -> wvalid_o drops at N+2, awvalid_o stays high until N+5, bready_o from N+6, resp_err_o=0.
- Write error: slave bresp_i=2'b10 -> resp_err_o=1, resp_rdata_o=0.
- Response backpressure: resp_ready_i low 7 cycles -> resp_valid_o and resp_rdata_o held; req_ready_o stays 0 until the cycle after resp fire.
- Reset during RD_DATA: rst_i high 1 cycle -> next cycle all valids/readies are 0, state IDLE; a new read then completes normally.

Source files
------------

// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI-lite initiator bridging a core load/store request port.
// Every AXI and core-side output is a flop; the FSM owns all of them.
module axi_lite_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [STRB_WIDTH-1:0] req_wstrb_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o,
    output logic [ADDR_WIDTH-1:0] araddr_o,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic                  rvalid_i,
    output logic                  rready_o,
    output logic [ADDR_WIDTH-1:0] awaddr_o,
    output logic                  awvalid_o,
    input  logic                  awready_i,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [STRB_WIDTH-1:0] wstrb_o,
    output logic                  wvalid_o,
    input  logic                  wready_i,
    input  logic [1:0]            bresp_i,
    input  logic                  bvalid_i,
    output logic                  bready_o
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP} state_t;

    state_t state;
    logic   aw_done, w_done;
    logic   aw_fire, w_fire;

    assign aw_fire = awvalid_o && awready_i;
    assign w_fire  = wvalid_o && wready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            req_ready_o  <= 1'b0;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= '0;
            resp_err_o   <= 1'b0;
            araddr_o     <= '0;
            arvalid_o    <= 1'b0;
            rready_o     <= 1'b0;
            awaddr_o     <= '0;
            awvalid_o    <= 1'b0;
            wdata_o      <= '0;
            wstrb_o      <= '0;
            wvalid_o     <= 1'b0;
            bready_o     <= 1'b0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready_o <= 1'b1;
                    if (req_valid_i && req_ready_o) begin
                        req_ready_o <= 1'b0;
                        araddr_o    <= req_addr_i;
                        awaddr_o    <= req_addr_i;
                        wdata_o     <= req_wdata_i;
                        wstrb_o     <= req_wstrb_i;
                        aw_done     <= 1'b0;
                        w_done      <= 1'b0;
                        if (req_we_i) begin
                            awvalid_o <= 1'b1;
                            wvalid_o  <= 1'b1;
                            state     <= WR_REQ;
                        end else begin
                            arvalid_o <= 1'b1;
                            state     <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (arvalid_o && arready_i) begin
                        arvalid_o <= 1'b0;
                        rready_o  <= 1'b1;
                        state     <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rready_o && rvalid_i) begin
                        rready_o     <= 1'b0;
                        resp_rdata_o <= rdata_i;
                        resp_err_o   <= 1'b0;
                        resp_valid_o <= 1'b1;
                        state        <= RESP;
                    end
                end
                WR_REQ: begin
                    // AW and W complete independently, in either order or together
                    if (aw_fire) begin
                        awvalid_o <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_fire) begin
                        wvalid_o <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                        bready_o <= 1'b1;
                        state    <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bready_o && bvalid_i) begin
                        bready_o     <= 1'b0;
                        resp_err_o   <= bresp_i != 2'b00;
                        resp_rdata_o <= '0;
                        resp_valid_o <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        req_ready_o  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: directed scenario tasks with hand-computed expectations.
// Inputs change and outputs are sampled on the falling edge.
module tb_axi_lite_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        resp_valid, resp_ready = 1'b0, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] araddr, awaddr, wdata, rdata = '0;
    logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic [3:0]  wstrb;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b0, bready;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    axi_lite_master dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
        .araddr_o(araddr), .arvalid_o(arvalid), .arready_i(arready),
        .rdata_i(rdata), .rvalid_i(rvalid), .rready_o(rready),
        .awaddr_o(awaddr), .awvalid_o(awvalid), .awready_i(awready),
        .wdata_o(wdata), .wstrb_o(wstrb), .wvalid_o(wvalid), .wready_i(wready),
        .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready)
    );

    task automatic test_reset;
        logic [8:0] outs;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        outs = {req_ready, resp_valid, resp_err, arvalid, rready, awvalid, wvalid, bready, |resp_rdata};
        checks++;
        if (outs !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", outs, 9'b0);
        end
        checks++;
        if ({araddr, awaddr, wdata, wstrb} !== '0) begin
            errors++;
            $display("FAIL reset_axi_fields: got %h expected 0", {araddr, awaddr, wdata, wstrb});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_read_zero_wait(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rd0_req_ready: got %b expected 1", req_ready);
        end
        req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
        arready = 1'b1; rvalid = 1'b1; rdata = data; resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({arvalid, rready, req_ready} !== 3'b100 || araddr !== addr) begin
            errors++;
            $display("FAIL rd0_ar_n1: got arvalid/rready/req_ready=%b araddr=%h expected 100 %h",
                     {arvalid, rready, req_ready}, araddr, addr);
        end
        @(negedge clk);
        checks++;
        if ({arvalid, rready, resp_valid} !== 3'b010) begin
            errors++;
            $display("FAIL rd0_r_n2: got arvalid/rready/resp_valid=%b expected 010", {arvalid, rready, resp_valid});
        end
        @(negedge clk);
        checks++;
        if ({resp_valid, resp_err, rready} !== 3'b100 || resp_rdata !== data) begin
            errors++;
            $display("FAIL rd0_resp_n3: got valid/err/rready=%b rdata=%h expected 100 %h",
                     {resp_valid, resp_err, rready}, resp_rdata, data);
        end
        resp_ready = 1'b1; arready = 1'b0; rvalid = 1'b0;
        @(negedge clk);
        resp_ready = 1'b0;
        checks++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL rd0_done: got resp_valid/req_ready=%b expected 01", {resp_valid, req_ready});
        end
    endtask

    task automatic test_write_error;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h4000_0008;
        req_wdata = 32'hA5A5_5A5A; req_wstrb = 4'b1111;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b10;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({awvalid, wvalid, bready} !== 3'b110 || awaddr !== 32'h4000_0008 || wdata !== 32'hA5A5_5A5A) begin
            errors++;
            $display("FAIL werr_n1: got aw/w/b=%b awaddr=%h wdata=%h expected 110 40000008 a5a55a5a",
                     {awvalid, wvalid, bready}, awaddr, wdata);
        end
        @(negedge clk);
        checks++;
        if ({awvalid, wvalid, bready} !== 3'b001) begin
            errors++;
            $display("FAIL werr_n2: got aw/w/b=%b expected 001", {awvalid, wvalid, bready});
        end
        @(negedge clk);
        checks++;
        if ({resp_valid, resp_err} !== 2'b11 || resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL werr_resp: got valid/err=%b rdata=%h expected 11 00000000", {resp_valid, resp_err}, resp_rdata);
        end
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_read_slow;
        int  ar_fires = 0;
        int  r_fires = 0;
        int  ar_at = -1;
        bit  done = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0100;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            arready = i >= 4;
            rvalid = ar_at >= 0 && i >= ar_at + 10;
            rdata = 32'hCAFE_F00D;
            if (arvalid) begin
                checks++;
                if (araddr !== 32'h0000_0100) begin
                    errors++;
                    $display("FAIL slow_araddr_stable: got %h expected 00000100 at step %0d", araddr, i);
                end
            end
            if (arvalid && arready) begin
                ar_fires++;
                ar_at = i;
            end
            if (rvalid && rready) r_fires++;
            if (resp_valid) done = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!done || ar_fires != 1 || r_fires != 1) begin
            errors++;
            $display("FAIL slow_handshakes: got done=%0d ar=%0d r=%0d expected 1 1 1", done, ar_fires, r_fires);
        end
        checks++;
        if (resp_rdata !== 32'hCAFE_F00D || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL slow_data: got %h err=%b expected cafef00d 0", resp_rdata, resp_err);
        end
        arready = 1'b0; rvalid = 1'b0; resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_write_skew;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h2000_0040;
        req_wdata = 32'h1234_5678; req_wstrb = 4'b0011;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({awvalid, wvalid} !== 2'b11 || awaddr !== 32'h2000_0040 || wdata !== 32'h1234_5678 || wstrb !== 4'b0011) begin
            errors++;
            $display("FAIL wskew_n1: got aw/w=%b awaddr=%h wdata=%h wstrb=%b expected 11 20000040 12345678 0011",
                     {awvalid, wvalid}, awaddr, wdata, wstrb);
        end
        wready = 1'b1;
        @(negedge clk);
        wready = 1'b0;
        checks++;
        if ({awvalid, wvalid, bready} !== 3'b100) begin
            errors++;
            $display("FAIL wskew_n2: got aw/w/b=%b expected 100", {awvalid, wvalid, bready});
        end
        for (int n = 3; n <= 5; n++) begin
            @(negedge clk);
            checks++;
            if ({awvalid, wvalid, bready} !== 3'b100 || awaddr !== 32'h2000_0040) begin
                errors++;
                $display("FAIL wskew_hold_n%0d: got aw/w/b=%b awaddr=%h expected 100 20000040",
                         n, {awvalid, wvalid, bready}, awaddr);
            end
        end
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        checks++;
        if ({awvalid, wvalid, bready} !== 3'b001) begin
            errors++;
            $display("FAIL wskew_n6: got aw/w/b=%b expected 001", {awvalid, wvalid, bready});
        end
        bvalid = 1'b1; bresp = 2'b00;
        @(negedge clk);
        bvalid = 1'b0;
        checks++;
        if ({resp_valid, resp_err, bready} !== 3'b100 || resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL wskew_resp: got valid/err/bready=%b rdata=%h expected 100 0",
                     {resp_valid, resp_err, bready}, resp_rdata);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL wskew_done: got req_ready=%b expected 1", req_ready);
        end
    endtask

    task automatic test_resp_backpressure;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0200;
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h0BAD_F00D;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        arready = 1'b0; rvalid = 1'b0; rdata = 32'hFFFF_FFFF;
        for (int n = 0; n < 7; n++) begin
            checks++;
            if ({resp_valid, req_ready} !== 2'b10 || resp_rdata !== 32'h0BAD_F00D) begin
                errors++;
                $display("FAIL bp_hold_%0d: got valid/req_ready=%b rdata=%h expected 10 0badf00d",
                         n, {resp_valid, req_ready}, resp_rdata);
            end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        checks++;
        if ({resp_valid, req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL bp_fire_cycle: got valid/req_ready=%b expected 10", {resp_valid, req_ready});
        end
        @(negedge clk);
        resp_ready = 1'b0;
        checks++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_after: got valid/req_ready=%b expected 01", {resp_valid, req_ready});
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0300;
        arready = 1'b1; rvalid = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        arready = 1'b0;
        checks++;
        if (rready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_in_rd_data: got rready=%b expected 1", rready);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({req_ready, resp_valid, arvalid, rready, awvalid, wvalid, bready} !== 7'b0) begin
            errors++;
            $display("FAIL rstmid_cleared: got %b expected 0000000",
                     {req_ready, resp_valid, arvalid, rready, awvalid, wvalid, bready});
        end
        test_read_zero_wait(32'h0000_0404, 32'h5555_AAAA);
    endtask

    initial begin
        test_reset();
        test_read_zero_wait(32'h8000_0010, 32'hDEAD_BEEF);
        test_write_error();
        test_read_slow();
        test_write_skew();
        test_resp_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
